// File: rtl/dm.sv
// Debug-module DMI types shared between the transport and the DM side.
package dm;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  localparam logic [1:0] DTM_SUCCESS = 2'h0;
  localparam logic [1:0] DTM_ERR     = 2'h2;

  // op is kept as raw bits so the reserved encoding 2'b11 can travel on the bus
  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/uart_pkg.sv
// UART debug transport shared definitions used by the DMI responder.
package uart_pkg;

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_exec = 2'd1,
    st_resp = 2'd2
  } dmi_resp_state_t;

  localparam logic [6:0]  DMI_BASE_ADDR_DEFAULT = 7'h04;
  localparam int unsigned DMI_DATA_W            = 32;

endpackage

// File: rtl/dmi_regbank.sv
// Scratch register bank behind the DMI responder: one write port, one combinational read port.
module dmi_regbank
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned IDX_W    = 4
) (
  input  logic                  CLK_I,
  input  logic                  RST_NI,
  input  logic                  CLR_I,
  input  logic                  WE_I,
  input  logic [IDX_W-1:0]      IDX_I,
  input  logic [DMI_DATA_W-1:0] WDATA_I,
  output logic [DMI_DATA_W-1:0] RDATA_C
);

  logic [DMI_DATA_W-1:0] regs_q [NUM_REGS];

  // Register storage; synchronous clear wins over a write in the same cycle
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (CLR_I) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (WE_I) begin
      regs_q[IDX_I] <= WDATA_I;
    end
  end

  // Combinational read at the shared index
  always_comb begin
    RDATA_C = regs_q[IDX_I];
  end

endmodule

// File: rtl/dmi_responder.sv
// DM-side DMI responder: one outstanding request, fixed latency, held response.
module dmi_responder
  import dm::*;
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REGS        = 16,
  parameter logic [6:0]  BASE_ADDR       = DMI_BASE_ADDR_DEFAULT,
  parameter int unsigned RESP_LATENCY    = 2,
  parameter bit          ERR_ON_UNMAPPED = 1'b1
) (
  input  logic      CLK_I,
  input  logic      RST_NI,
  input  logic      DMI_RST_NI,
  input  logic      DMI_REQ_VALID_I,
  output logic      DMI_REQ_READY_O,
  input  dmi_req_t  DMI_REQ_I,
  output logic      DMI_RESP_VALID_O,
  input  logic      DMI_RESP_READY_I,
  output dmi_resp_t DMI_RESP_O,
  output logic      BUSY_O
);

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0]  UNMAPPED_RESP = ERR_ON_UNMAPPED ? DTM_ERR : DTM_SUCCESS;

  dmi_resp_state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  dmi_req_t         req_q;
  dmi_resp_t        resp_q;
  logic             ready_q;
  logic             valid_q;
  logic             busy_q;

  logic [ADDR_W-1:0]     off_c;
  logic                  mapped_c;
  logic [IDX_W-1:0]      idx_c;
  logic                  exec_c;
  logic                  we_c;
  logic [DMI_DATA_W-1:0] rdata_c;
  dmi_resp_t             exec_resp_c;

  // Address decode and register-bank write strobe for the execute cycle
  always_comb begin
    off_c    = req_q.addr - BASE_ADDR;
    mapped_c = (off_c < ADDR_W'(NUM_REGS));
    idx_c    = off_c[IDX_W-1:0];
    exec_c   = (state_q == st_exec) && (cnt_q == '0);
    we_c     = exec_c && DMI_RST_NI && mapped_c && (req_q.op == DTM_WRITE);
  end

  // Response produced by executing the latched request
  always_comb begin
    exec_resp_c      = '0;
    exec_resp_c.resp = DTM_SUCCESS;
    case (req_q.op)
      DTM_NOP: ;
      DTM_READ: begin
        if (mapped_c) exec_resp_c.data = rdata_c;
        else          exec_resp_c.resp = UNMAPPED_RESP;
      end
      DTM_WRITE: begin
        if (mapped_c) exec_resp_c.data = req_q.data;
        else          exec_resp_c.resp = UNMAPPED_RESP;
      end
      default: exec_resp_c.resp = DTM_ERR;
    endcase
  end

  dmi_regbank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regbank (
    .CLK_I   (CLK_I),
    .RST_NI  (RST_NI),
    .CLR_I   (!DMI_RST_NI),
    .WE_I    (we_c),
    .IDX_I   (idx_c),
    .WDATA_I (req_q.data),
    .RDATA_C (rdata_c)
  );

  // Request/execute/response FSM with latency counter and registered handshake outputs
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q <= st_idle;
      cnt_q   <= '0;
      req_q   <= '0;
      resp_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (!DMI_RST_NI) begin
      state_q <= st_idle;
      cnt_q   <= '0;
      req_q   <= '0;
      resp_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        st_idle: begin
          if (DMI_REQ_VALID_I && ready_q) begin
            req_q   <= DMI_REQ_I;
            cnt_q   <= CNT_W'(RESP_LATENCY);
            state_q <= st_exec;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            ready_q <= 1'b1;
          end
        end
        st_exec: begin
          if (cnt_q == '0) begin
            resp_q  <= exec_resp_c;
            valid_q <= 1'b1;
            state_q <= st_resp;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        st_resp: begin
          if (DMI_RESP_READY_I) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= st_idle;
          end
        end
        default: begin
          state_q <= st_idle;
          ready_q <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign DMI_REQ_READY_O  = ready_q;
  assign DMI_RESP_VALID_O = valid_q;
  assign DMI_RESP_O       = resp_q;
  assign BUSY_O           = busy_q;

endmodule

// File: tb/tb_dmi_responder.sv
// Directed scoreboard bench for dmi_responder across default, zero and maximum latency configurations.
module tb_dmi_responder;
  import dm::*;

  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic      rst_n;
  logic      dmi_rst_n;
  logic      req_valid  [ND];
  logic      resp_ready [ND];
  dmi_req_t  req        [ND];
  logic      req_ready  [ND];
  logic      resp_valid [ND];
  dmi_resp_t resp       [ND];
  logic      busy       [ND];

  int checks = 0;
  int errors = 0;
  dmi_resp_t exp_q [$];

  // Default configuration: latency 2, unmapped accesses error
  dmi_responder u_dut0 (
    .CLK_I(clk), .RST_NI(rst_n), .DMI_RST_NI(dmi_rst_n),
    .DMI_REQ_VALID_I(req_valid[0]), .DMI_REQ_READY_O(req_ready[0]), .DMI_REQ_I(req[0]),
    .DMI_RESP_VALID_O(resp_valid[0]), .DMI_RESP_READY_I(resp_ready[0]), .DMI_RESP_O(resp[0]),
    .BUSY_O(busy[0]));

  // Zero latency, unmapped accesses succeed
  dmi_responder #(.RESP_LATENCY(0), .ERR_ON_UNMAPPED(1'b0)) u_dut1 (
    .CLK_I(clk), .RST_NI(rst_n), .DMI_RST_NI(dmi_rst_n),
    .DMI_REQ_VALID_I(req_valid[1]), .DMI_REQ_READY_O(req_ready[1]), .DMI_REQ_I(req[1]),
    .DMI_RESP_VALID_O(resp_valid[1]), .DMI_RESP_READY_I(resp_ready[1]), .DMI_RESP_O(resp[1]),
    .BUSY_O(busy[1]));

  // Maximum latency
  dmi_responder #(.RESP_LATENCY(15)) u_dut2 (
    .CLK_I(clk), .RST_NI(rst_n), .DMI_RST_NI(dmi_rst_n),
    .DMI_REQ_VALID_I(req_valid[2]), .DMI_REQ_READY_O(req_ready[2]), .DMI_REQ_I(req[2]),
    .DMI_RESP_VALID_O(resp_valid[2]), .DMI_RESP_READY_I(resp_ready[2]), .DMI_RESP_O(resp[2]),
    .BUSY_O(busy[2]));

  function automatic dmi_req_t mk(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d);
    dmi_req_t r;
    r.addr = a;
    r.op   = op;
    r.data = d;
    return r;
  endfunction

  function automatic dmi_resp_t rs(input logic [31:0] d, input logic [1:0] c);
    dmi_resp_t r;
    r.data = d;
    r.resp = c;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge and return at the negedge after it is accepted
  task automatic issue(input int d, input dmi_req_t r, input dmi_resp_t e);
    int n = 0;
    exp_q.push_back(e);
    req[d] = r;
    req_valid[d] = 1'b1;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(n < 50), 64'(1));
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  // Count edges from acceptance until the response shows, then compare against the scoreboard
  task automatic await_resp(input int d, input int exp_lat);
    int lat = 0;
    dmi_resp_t e;
    while (!resp_valid[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("sb_nonempty", 64'(exp_q.size() > 0), 64'(1));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("resp", 64'(resp[d]), 64'(e));
    end
  endtask

  task automatic handshake(input int d);
    resp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[d] = 1'b0;
    chk("valid_drop", 64'(resp_valid[d]), 64'(0));
    chk("ready_back", 64'(req_ready[d]), 64'(1));
  endtask

  task automatic txn(input int d, input dmi_req_t r, input dmi_resp_t e, input int lat);
    issue(d, r, e);
    await_resp(d, lat);
    handshake(d);
  endtask

  // Streaming NOPs with both valid and resp_ready held high; checks request period
  task automatic b2b(input int d, input int per);
    int acc [$];
    int cyc = 0;
    int n = 0;
    dmi_resp_t e;
    req[d] = mk(7'h00, 2'b00, 32'h0);
    req_valid[d] = 1'b1;
    resp_ready[d] = 1'b1;
    while (acc.size() < 4 && cyc < 200) begin
      if (req_ready[d]) begin
        acc.push_back(cyc);
        exp_q.push_back(rs(32'h0, DTM_SUCCESS));
      end
      if (resp_valid[d] && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("b2b_resp", 64'(resp[d]), 64'(e));
      end
      @(negedge clk);
      cyc++;
    end
    req_valid[d] = 1'b0;
    while (exp_q.size() > 0 && n < 40) begin
      if (resp_valid[d]) begin
        e = exp_q.pop_front();
        chk("b2b_resp", 64'(resp[d]), 64'(e));
      end
      @(negedge clk);
      n++;
    end
    resp_ready[d] = 1'b0;
    chk("b2b_drained", 64'(exp_q.size()), 64'(0));
    chk("b2b_count", 64'(acc.size()), 64'(4));
    for (int i = 1; i < acc.size(); i++) chk("b2b_period", 64'(acc[i] - acc[i-1]), 64'(per));
  endtask

  initial begin
    int n;
    logic seen;
    rst_n = 1'b0;
    dmi_rst_n = 1'b1;
    for (int d = 0; d < ND; d++) begin
      req_valid[d] = 1'b0;
      resp_ready[d] = 1'b0;
      req[d] = '0;
    end

    // Power-on reset
    @(negedge clk);
    chk("rst_ready", 64'(req_ready[0]), 64'(0));
    chk("rst_valid", 64'(resp_valid[0]), 64'(0));
    chk("rst_resp", 64'(resp[0]), 64'(0));
    chk("rst_busy", 64'(busy[0]), 64'(0));
    rst_n = 1'b1;
    #1 chk("ready_before_edge", 64'(req_ready[0]), 64'(0));
    @(negedge clk);
    chk("ready_after_rst", 64'(req_ready[0]), 64'(1));

    // Write/read and decode boundaries on the default instance
    txn(0, mk(7'h05, 2'b10, 32'hDEADBEEF), rs(32'hDEADBEEF, DTM_SUCCESS), 3);
    txn(0, mk(7'h05, 2'b01, 32'h0), rs(32'hDEADBEEF, DTM_SUCCESS), 3);
    txn(0, mk(7'h04, 2'b01, 32'h0), rs(32'h0, DTM_SUCCESS), 3);
    txn(0, mk(7'h7F, 2'b01, 32'h0), rs(32'h0, DTM_ERR), 3);
    txn(0, mk(7'h05, 2'b11, 32'h11111111), rs(32'h0, DTM_ERR), 3);
    txn(0, mk(7'h05, 2'b01, 32'h0), rs(32'hDEADBEEF, DTM_SUCCESS), 3);
    txn(0, mk(7'h13, 2'b10, 32'h00C0FFEE), rs(32'h00C0FFEE, DTM_SUCCESS), 3);
    txn(0, mk(7'h14, 2'b10, 32'h12345678), rs(32'h0, DTM_ERR), 3);
    txn(0, mk(7'h03, 2'b01, 32'h0), rs(32'h0, DTM_ERR), 3);
    txn(0, mk(7'h13, 2'b01, 32'h0), rs(32'h00C0FFEE, DTM_SUCCESS), 3);
    txn(0, mk(7'h05, 2'b00, 32'hFFFFFFFF), rs(32'h0, DTM_SUCCESS), 3);

    // Backpressure: response held for 10 cycles while a second request waits
    issue(0, mk(7'h07, 2'b10, 32'hCAFEF00D), rs(32'hCAFEF00D, DTM_SUCCESS));
    await_resp(0, 3);
    req[0] = mk(7'h07, 2'b01, 32'h0);
    req_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(resp_valid[0]), 64'(1));
      chk("bp_data", 64'(resp[0]), 64'(rs(32'hCAFEF00D, DTM_SUCCESS)));
      chk("bp_ready", 64'(req_ready[0]), 64'(0));
    end
    resp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[0] = 1'b0;
    chk("bp_hs_valid", 64'(resp_valid[0]), 64'(0));
    chk("bp_hs_ready", 64'(req_ready[0]), 64'(1));
    chk("bp_hs_busy", 64'(busy[0]), 64'(0));
    exp_q.push_back(rs(32'hCAFEF00D, DTM_SUCCESS));
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("bp_second_busy", 64'(busy[0]), 64'(1));
    await_resp(0, 3);
    handshake(0);

    // Soft reset during a pending response
    issue(0, mk(7'h06, 2'b10, 32'h00001234), rs(32'h00001234, DTM_SUCCESS));
    await_resp(0, 3);
    dmi_rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    dmi_rst_n = 1'b1;
    chk("srst_valid", 64'(resp_valid[0]), 64'(0));
    chk("srst_ready", 64'(req_ready[0]), 64'(0));
    chk("srst_resp", 64'(resp[0]), 64'(0));
    chk("srst_busy", 64'(busy[0]), 64'(0));
    @(negedge clk);
    chk("srst_ready_back", 64'(req_ready[0]), 64'(1));
    txn(0, mk(7'h06, 2'b01, 32'h0), rs(32'h0, DTM_SUCCESS), 3);
    txn(0, mk(7'h05, 2'b01, 32'h0), rs(32'h0, DTM_SUCCESS), 3);

    // Hard reset in the middle of execution aborts the write
    txn(0, mk(7'h08, 2'b10, 32'h5A5A5A5A), rs(32'h5A5A5A5A, DTM_SUCCESS), 3);
    req[0] = mk(7'h08, 2'b10, 32'hAAAA0000);
    req_valid[0] = 1'b1;
    n = 0;
    while (!req_ready[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("abort_in_exec", 64'(busy[0]), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 64'(req_ready[0]), 64'(0));
    chk("abort_valid", 64'(resp_valid[0]), 64'(0));
    chk("abort_resp", 64'(resp[0]), 64'(0));
    chk("abort_busy", 64'(busy[0]), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen = seen | resp_valid[0];
    end
    chk("abort_no_resp", 64'(seen), 64'(0));
    chk("abort_ready_back", 64'(req_ready[0]), 64'(1));
    txn(0, mk(7'h08, 2'b01, 32'h0), rs(32'h0, DTM_SUCCESS), 3);

    // Zero latency, unmapped accesses succeed
    txn(1, mk(7'h7F, 2'b01, 32'h0), rs(32'h0, DTM_SUCCESS), 1);
    txn(1, mk(7'h05, 2'b11, 32'h0), rs(32'h0, DTM_ERR), 1);
    txn(1, mk(7'h05, 2'b10, 32'h00000055), rs(32'h00000055, DTM_SUCCESS), 1);
    txn(1, mk(7'h05, 2'b01, 32'h0), rs(32'h00000055, DTM_SUCCESS), 1);
    b2b(1, 3);

    // Maximum latency
    txn(2, mk(7'h04, 2'b01, 32'h0), rs(32'h0, DTM_SUCCESS), 16);
    b2b(2, 18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmi_responder.md
# dmi_responder

DM-side responder for the DMI ready/valid bus driven by the UART debug transport. Accepts one `dmi_req_t` at a time and executes it against a small local register bank. Returns a `dmi_resp_t` after a fixed, configurable latency and holds it until the initiator accepts it. Serves as the bring-up/verification stand-in for the debug module and as a scratch register window behind the DMI.

## Interface
- `NUM_REGS`, default 16: number of 32-bit registers in the bank; power of two, 1..64.
- `BASE_ADDR`, default 7'h04: DMI address of register 0; mapped range is `BASE_ADDR`..`BASE_ADDR+NUM_REGS-1`, and it must not exceed 7'h7F.
- `RESP_LATENCY`, default 2: cycles from request acceptance to response valid, 0..15.
- `ERR_ON_UNMAPPED`, default 1: 1 = unmapped accesses respond `DTM_ERR`; 0 = they respond `DTM_SUCCESS`.
- `CLK_I` in 1: clock.
- `RST_NI` in 1: asynchronous active-low reset.
- `DMI_RST_NI` in 1: synchronous active-low DMI soft reset (hard-reset passthrough from the transport).
- `DMI_REQ_VALID_I` in 1: request valid.
- `DMI_REQ_READY_O` out 1: responder can accept a request.
- `DMI_REQ_I` in `$bits(dmi_req_t)`: request {addr[6:0], op[1:0], data[31:0]}.
- `DMI_RESP_VALID_O` out 1: response valid.
- `DMI_RESP_READY_I` in 1: initiator accepts the response.
- `DMI_RESP_O` out `$bits(dmi_resp_t)`: response {data[31:0], resp[1:0]}.
- `BUSY_O` out 1: a request is in flight (any state other than idle).

## Operation
- FSM states:
  - `st_idle`: `DMI_REQ_READY_O`=1. On valid&ready, latch the request, load the latency counter with `RESP_LATENCY`, and go to `st_exec`.
  - `st_exec`: the counter decrements each cycle. When the counter is 0, execute the request and go to `st_resp`. With `RESP_LATENCY`=0, the request executes in the first `st_exec` cycle.
  - `st_resp`: `DMI_RESP_VALID_O`=1 and `DMI_RESP_O` is stable. On `DMI_RESP_READY_I`=1, go to `st_idle`.
- Only one request is outstanding at a time. Ready is low in `st_exec` and `st_resp`. A request presented there is not accepted; the initiator holds it.
- Execution, where index = addr - `BASE_ADDR` (7-bit subtract; mapped iff addr is within range):
  - `DTM_NOP`: data=0, resp=`DTM_SUCCESS`. No side effect.
  - `DTM_READ` mapped: data=reg[index], resp=`DTM_SUCCESS`.
  - `DTM_WRITE` mapped: reg[index] is written in the execute cycle. Response data = the written value, resp=`DTM_SUCCESS`.
  - Unmapped read or write: data=0, resp=`DTM_ERR` (or `DTM_SUCCESS` if `ERR_ON_UNMAPPED`=0). No side effect.
  - op=2'b11 (reserved): data=0, resp=`DTM_ERR` regardless of the parameter. No side effect.
- `DMI_RST_NI`=0, sampled each cycle:
  - Clears all registers, forces `st_idle`, discards any latched request or pending response.
  - Holds `DMI_REQ_READY_O`=0 while asserted.
  - Takes precedence over every other event in the same cycle.

## Timing
- While `RST_NI`=0 (asynchronous): `DMI_REQ_READY_O`=0, `DMI_RESP_VALID_O`=0, `DMI_RESP_O`='0, `BUSY_O`=0, registers all 0, state `st_idle`. `DMI_REQ_READY_O` rises the first cycle after deassertion.
- Acceptance at edge k → `DMI_RESP_VALID_O` high from cycle k+2+`RESP_LATENCY`. Default latency 2 → response visible 4 cycles after the accept edge.
- Back-to-back throughput: response handshake at edge m → ready=1 in cycle m+1. Minimum request period is 3+`RESP_LATENCY` cycles when `DMI_RESP_READY_I` is held at 1.
- `DMI_RESP_O` changes only on entry to `st_resp`. It keeps its last value afterwards and is '0 after any reset.
- A read following a write to the same address returns the new value; there is no hazard, because execution is serialized.
- `RST_NI` asserted mid-transaction aborts immediately. No response is emitted and a partially latched write is not committed.

## Structure
- Use `dm::dmi_req_t`, `dm::dmi_resp_t`, `dtm_op_e`, `DTM_SUCCESS`, `DTM_ERR` from the dm package.
- The state enum `dmi_resp_state_t` and the default `BASE_ADDR` constant belong in `uart_pkg`.
- Sub-module `dmi_regbank`:
  - `NUM_REGS`×32 flops with a synchronous write port and a combinational read port.
  - Synchronous clear input driven by `DMI_RST_NI`.
  - Asynchronous reset from `RST_NI`.
- Top level holds the FSM, the latency counter, and the response register.

## Test plan
- Reset: assert `RST_NI`=0 mid-`st_exec` → all outputs 0 asynchronously; after release, ready=1 and no response is ever emitted for the aborted request.
- Write/read: WRITE addr 7'h05 data 32'hDEADBEEF → resp {32'hDEADBEEF, `DTM_SUCCESS`} at k+4; READ 7'h05 → {32'hDEADBEEF, `DTM_SUCCESS`}; READ 7'h04 → {0, `DTM_SUCCESS`}.
- Unmapped/reserved:
  - READ 7'h7F → {0, `DTM_ERR`}.
  - op=3 at 7'h05 → {0, `DTM_ERR`} and reg[1] unchanged.
  - With `ERR_ON_UNMAPPED`=0, READ 7'h7F → {0, `DTM_SUCCESS`}.
- Backpressure: hold `DMI_RESP_READY_I`=0 for 10 cycles → valid and data stable, `DMI_REQ_READY_O`=0, and a second request is not accepted until one cycle after the response handshake.
- Soft reset: write 32'h1234 to 7'h06, pulse `DMI_RST_NI`=0 for 1 cycle during `st_resp` → the pending response is dropped; a subsequent READ 7'h06 → {0, `DTM_SUCCESS`}.
- Latency sweep: `RESP_LATENCY`=0 and 15 → valid observed exactly at k+2 and k+17; back-to-back NOPs with ready=1 complete one per 3+L cycles.
